// File: rtl/road_pixel_gen.sv
// Road pixel decoder: latches the road edge per frame, flags road/edge/stripe pixels
// and tracks off-road car pixels into a sticky crash flag. ROAD_DASH_EN selects a scrolling dashed stripe.
module road_pixel_gen #(
  parameter int unsigned ROAD_W     = 160,
  parameter int unsigned EDGE_W     = 8,
  parameter int unsigned STRIPE_W   = 4,
  parameter int unsigned DASH_LEN   = 16,
  parameter int unsigned DASH_SPEED = 2,
  parameter int unsigned HIT_THRESH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame,
  input  logic        active,
  input  logic [15:0] h_pix,
  input  logic [15:0] v_pix,
  input  logic [15:0] road_h_address,
  input  logic        car_pix,
  input  logic        dash_run,
  input  logic        crash_clr,
  output logic [15:0] road_left_q,
  output logic        road_px,
  output logic        edge_px,
  output logic        stripe_px,
  output logic        crash
);

  typedef enum logic {NORMAL, CRASHED} state_t;

  state_t      state_q;
  logic [7:0]  offcnt_q;
  logic        road_q, edge_q, stripe_q;

  logic [16:0] right_w;
  logic [15:0] right;
  logic [16:0] band_lo, band_hi;
  logic        inroad, edge_w, band, dash_on, hit;

  // Right edge is formed at 17 bits so a road near the top of the range clips instead of wrapping.
  always_comb begin
    right_w = {1'b0, road_left_q} + 17'(ROAD_W) - 17'd1;
    right   = right_w[16] ? 16'hFFFF : right_w[15:0];
    band_lo = {1'b0, road_left_q} + 17'(ROAD_W / 2 - STRIPE_W / 2);
    band_hi = {1'b0, road_left_q} + 17'(ROAD_W / 2 + STRIPE_W / 2);
  end

  always_comb begin
    inroad = active && (h_pix >= road_left_q) && (h_pix <= right);
    edge_w = inroad && ((16'(h_pix - road_left_q) < 16'(EDGE_W)) ||
                        (16'(right - h_pix) < 16'(EDGE_W)));
    band   = ({1'b0, h_pix} >= band_lo) && ({1'b0, h_pix} < band_hi);
    hit    = active && car_pix && !inroad;
  end

`ifdef ROAD_DASH_EN
  logic [6:0]  dash_ofs_q;
  logic [16:0] dash_sum;

  always_comb begin
    dash_sum = ({1'b0, v_pix} + {10'b0, dash_ofs_q}) & 17'(2 * DASH_LEN - 1);
    dash_on  = dash_sum < 17'(DASH_LEN);
  end

  // 2*DASH_LEN divides 128, so wrapping the 7-bit add first keeps the modulo exact.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dash_ofs_q <= '0;
    end else if (frame && dash_run) begin
      dash_ofs_q <= 7'(dash_ofs_q + 7'(DASH_SPEED)) & 7'(2 * DASH_LEN - 1);
    end
  end
`else
  logic unused_nodash;
  assign dash_on       = 1'b1;
  assign unused_nodash = dash_run ^ (^v_pix);
`endif

  logic unused_addr_lsb;
  assign unused_addr_lsb = road_h_address[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      road_left_q <= '0;
      road_q      <= 1'b0;
      edge_q      <= 1'b0;
      stripe_q    <= 1'b0;
    end else begin
      if (frame) begin
        road_left_q <= {road_h_address[15:1], 1'b0};
      end
      road_q   <= inroad;
      edge_q   <= edge_w;
      stripe_q <= inroad && !edge_w && band && dash_on;
    end
  end

  // A crashing frame takes priority over a coincident clear; the frame-cycle hit seeds the next count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= NORMAL;
      offcnt_q <= '0;
    end else if (frame) begin
      offcnt_q <= hit ? 8'd1 : 8'd0;
      if (offcnt_q >= 8'(HIT_THRESH)) begin
        state_q <= CRASHED;
      end else if (crash_clr) begin
        state_q <= NORMAL;
      end
    end else begin
      if (hit && (offcnt_q != 8'hFF)) begin
        offcnt_q <= offcnt_q + 8'd1;
      end
      if (crash_clr) begin
        state_q <= NORMAL;
      end
    end
  end

  assign road_px   = road_q;
  assign edge_px   = edge_q;
  assign stripe_px = stripe_q;
  assign crash     = (state_q == CRASHED);

endmodule

// File: tb/tb_road_pixel_gen.sv
// Directed bench for road_pixel_gen: decode sweep, shadow latch, saturation, dash scroll and crash FSM.
module tb_road_pixel_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame;
  logic        active;
  logic [15:0] h_pix;
  logic [15:0] v_pix;
  logic [15:0] road_h_address;
  logic        car_pix;
  logic        dash_run;
  logic        crash_clr;
  logic [15:0] road_left_q;
  logic        road_px, edge_px, stripe_px, crash;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  road_pixel_gen #(
    .ROAD_W(160), .EDGE_W(8), .STRIPE_W(4),
    .DASH_LEN(16), .DASH_SPEED(2), .HIT_THRESH(4)
  ) dut (
    .clk(clk), .reset(reset), .frame(frame), .active(active),
    .h_pix(h_pix), .v_pix(v_pix), .road_h_address(road_h_address),
    .car_pix(car_pix), .dash_run(dash_run), .crash_clr(crash_clr),
    .road_left_q(road_left_q), .road_px(road_px), .edge_px(edge_px),
    .stripe_px(stripe_px), .crash(crash)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame(input logic [15:0] addr);
    road_h_address = addr;
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic decode(input logic [15:0] h, input logic [15:0] v, input string tag,
                        input logic er, input logic ee, input logic es);
    h_pix = h;
    v_pix = v;
    tick();
    check({tag, ".road"}, 32'(road_px), 32'(er));
    check({tag, ".edge"}, 32'(edge_px), 32'(ee));
    check({tag, ".stripe"}, 32'(stripe_px), 32'(es));
  endtask

  task automatic offroad(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      h_pix = 16'd50;
      car_pix = 1'b1;
      tick();
    end
    car_pix = 1'b0;
  endtask

  // Sweep table for road at 100..259: {h, road, edge, stripe}
  logic [15:0] sw_h [12] = '{16'd99, 16'd100, 16'd107, 16'd108, 16'd177, 16'd178,
                             16'd181, 16'd182, 16'd251, 16'd252, 16'd259, 16'd260};
  logic [2:0]  sw_e [12] = '{3'b000, 3'b110, 3'b110, 3'b100, 3'b100, 3'b101,
                             3'b101, 3'b100, 3'b100, 3'b110, 3'b110, 3'b000};

  initial begin
    reset = 1'b0; frame = 1'b0; active = 1'b0; h_pix = '0; v_pix = '0;
    road_h_address = '0; car_pix = 1'b0; dash_run = 1'b0; crash_clr = 1'b0;
    tick();
    tick();
    check("rst.left", 32'(road_left_q), 32'd0);
    check("rst.road", 32'(road_px), 32'd0);
    check("rst.crash", 32'(crash), 32'd0);
    reset = 1'b1;
    tick();

    // Decode sweep with defaults
    pulse_frame(16'd100);
    check("dec.left", 32'(road_left_q), 32'd100);
    active = 1'b1;
    for (int i = 0; i < 12; i++) begin
      decode(sw_h[i], 16'd0, $sformatf("sweep_h%0d", sw_h[i]), sw_e[i][2], sw_e[i][1], sw_e[i][0]);
    end
    active = 1'b0;
    decode(16'd150, 16'd0, "inactive", 1'b0, 1'b0, 1'b0);
    active = 1'b1;

    // Shadow latch: odd address rounds down, mid-frame change invisible
    pulse_frame(16'd101);
    check("shadow.left", 32'(road_left_q), 32'd100);
    road_h_address = 16'd200;
    decode(16'd100, 16'd0, "shadow_h100", 1'b1, 1'b1, 1'b0);
    decode(16'd259, 16'd0, "shadow_h259", 1'b1, 1'b1, 1'b0);
    decode(16'd99, 16'd0, "shadow_h99", 1'b0, 1'b0, 1'b0);
    check("shadow.hold", 32'(road_left_q), 32'd100);

    // Saturation of the right edge
    pulse_frame(16'hFFF0);
    check("sat.left", 32'(road_left_q), 32'hFFF0);
    decode(16'hFFFF, 16'd0, "sat_hFFFF", 1'b1, 1'b1, 1'b0);
    decode(16'h0000, 16'd0, "sat_h0", 1'b0, 1'b0, 1'b0);
    decode(16'hFFEF, 16'd0, "sat_hFFEF", 1'b0, 1'b0, 1'b0);

    // Dash scroll
    dash_run = 1'b1;
    pulse_frame(16'd100);
    pulse_frame(16'd100);
    pulse_frame(16'd100);
`ifdef ROAD_DASH_EN
    decode(16'd178, 16'd10, "dash_v10", 1'b1, 1'b0, 1'b0);
    decode(16'd178, 16'd9, "dash_v9", 1'b1, 1'b0, 1'b1);
    decode(16'd178, 16'd41, "dash_v41", 1'b1, 1'b0, 1'b1);
    dash_run = 1'b0;
    pulse_frame(16'd100);
    decode(16'd178, 16'd10, "hold_v10", 1'b1, 1'b0, 1'b0);
    decode(16'd178, 16'd9, "hold_v9", 1'b1, 1'b0, 1'b1);
`else
    decode(16'd178, 16'd10, "solid_v10", 1'b1, 1'b0, 1'b1);
    decode(16'd178, 16'd16, "solid_v16", 1'b1, 1'b0, 1'b1);
    decode(16'd179, 16'd31, "solid_v31", 1'b1, 1'b0, 1'b1);
    dash_run = 1'b0;
`endif
    v_pix = '0;

    // Crash threshold
    offroad(3);
    pulse_frame(16'd100);
    check("crash.3px", 32'(crash), 32'd0);
    offroad(4);
    pulse_frame(16'd100);
    check("crash.4px", 32'(crash), 32'd1);
    pulse_frame(16'd100);
    check("crash.sticky", 32'(crash), 32'd1);
    crash_clr = 1'b1;
    tick();
    crash_clr = 1'b0;
    check("crash.clr", 32'(crash), 32'd0);

    // Clear coinciding with a crashing frame: crash wins
    offroad(4);
    crash_clr = 1'b1;
    pulse_frame(16'd100);
    crash_clr = 1'b0;
    check("crash.clr_vs_frame", 32'(crash), 32'd1);
    crash_clr = 1'b1;
    tick();
    crash_clr = 1'b0;
    check("crash.clr2", 32'(crash), 32'd0);

    // Off-road pixel on the frame cycle counts toward the next frame
    offroad(3);
    car_pix = 1'b1;
    h_pix = 16'd50;
    pulse_frame(16'd100);
    car_pix = 1'b0;
    check("carry.first", 32'(crash), 32'd0);
    offroad(3);
    pulse_frame(16'd100);
    check("carry.second", 32'(crash), 32'd1);

    // Reset mid-frame with offcnt=3, crash=1
    offroad(3);
    decode(16'd150, 16'd0, "pre_rst", 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("arst.crash", 32'(crash), 32'd0);
    check("arst.road", 32'(road_px), 32'd0);
    check("arst.left", 32'(road_left_q), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    pulse_frame(16'd100);
    check("post_rst.frame0", 32'(crash), 32'd0);
    offroad(3);
    pulse_frame(16'd100);
    check("post_rst.discard", 32'(crash), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/road_pixel_gen.md
# road_pixel_gen

Consumer of the road horizontal address produced by the road scroll counter. It samples `road_h_address` once per frame, decodes each VGA pixel into road, edge and centre-stripe flags, and scrolls a dashed centre stripe frame by frame. It also counts car pixels that fall off the road each frame and raises a sticky crash flag. It sits between the road counter and the VGA colour mux.

## Interface
- `ROAD_W`, 160: road width in pixels; even, at least 2·`EDGE_W`.
- `EDGE_W`, 8: width of each edge band in pixels.
- `STRIPE_W`, 4: centre stripe width; even.
- `DASH_LEN`, 16: dash and gap length in lines; power of two, at most 64.
- `DASH_SPEED`, 2: lines the dash phase advances per frame; less than 2·`DASH_LEN`.
- `HIT_THRESH`, 4: off-road car pixels per frame that trigger a crash; 1..255.

Ports:
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame`  in  1  one-cycle pulse at end of frame (vertical blank).
- `active`  in  1  current pixel is in the visible region.
- `h_pix`  in  16  current pixel column.
- `v_pix`  in  16  current pixel row.
- `road_h_address`  in  16  left road edge from the road counter.
- `car_pix`  in  1  current pixel belongs to the car sprite.
- `dash_run`  in  1  enables dash scrolling (game running).
- `crash_clr`  in  1  synchronous clear of `crash`.
- `road_left_q`  out  16  latched left edge.
- `road_px`  out  1  pixel is road.
- `edge_px`  out  1  pixel is in an edge band.
- `stripe_px`  out  1  pixel is centre stripe.
- `crash`  out  1  sticky crash flag.

## Operation
- **Shadow latch:** on `frame`, `road_left_q <= {road_h_address[15:1],1'b0}`. Bit 0 is forced to 0. The latch holds between pulses, so mid-frame address changes are not visible.
- **Right edge:** `right = road_left_q + ROAD_W - 1`, computed at 17 bits and saturated to 0xFFFF. No wrap.
- **Road decode:** `inroad = active & (h_pix >= road_left_q) & (h_pix <= right)`.
- **Edge decode:** `edge = inroad & ((h_pix - road_left_q < EDGE_W) | (right - h_pix < EDGE_W))`.
- **Stripe band:** `h_pix` in [`road_left_q + ROAD_W/2 - STRIPE_W/2`, `road_left_q + ROAD_W/2 + STRIPE_W/2`).
  - `stripe = inroad & ~edge & band & dash_on`.
  - `dash_on = (((v_pix + dash_ofs) mod 2·DASH_LEN) < DASH_LEN)`.
- **Dash phase:** `dash_ofs` is 7 bits. On `frame` with `dash_run=1`: `dash_ofs <= (dash_ofs + DASH_SPEED) mod 2·DASH_LEN`. Otherwise it holds.
- **Crash FSM:** states NORMAL and CRASHED; `crash = (state==CRASHED)`.
  - `offcnt` is 8 bits, saturating at 255.
  - Increments on each cycle with `active & car_pix & ~inroad`.
  - On `frame`: if `offcnt >= HIT_THRESH`, go to CRASHED. `offcnt` then restarts at 0, or at 1 if an off-road pixel coincides with `frame`. That pixel counts toward the new frame.
  - CRASHED holds until `crash_clr` or reset.
  - If `crash_clr` and a crashing `frame` coincide, the crash wins and the state stays CRASHED.
- **Reset (`reset`=0):** asynchronous.
  - All outputs go to 0.
  - `road_left_q`=0, `dash_ofs`=0, `offcnt`=0, state NORMAL.
  - Reset mid-frame discards the partial count.

## Timing
- Pixel flags (`road_px`, `edge_px`, `stripe_px`) are registered: inputs sampled at edge N appear after edge N+1. Latency is 1 cycle with no bubbles; one pixel is decoded per clock.
- `road_left_q`, `dash_ofs` and `crash` update on the edge that samples `frame`=1.
- Pixels sampled on the `frame` cycle are decoded using the pre-update `road_left_q` and `dash_ofs`.
- `crash_clr` takes effect 1 cycle after it is sampled.

## Configuration
- `ROAD_DASH_EN` defined: dashed, scrolling stripe as described above.
- `ROAD_DASH_EN` undefined:
  - The dash counter is not built and `dash_ofs` is tied to 0.
  - `dash_on=1`, giving a solid centre line.
  - `dash_run` is ignored.

## Test plan
- **Decode with defaults:** reset, `road_h_address`=100, pulse `frame`, then sweep `h_pix` with `v_pix`=0 and `active`=1. Expected, 1 cycle later:
  - `road_px`=1 for h=100..259 and 0 at h=99 and 260.
  - `edge_px`=1 for h=100..107 and 252..259.
  - `stripe_px`=1 for h=178..181.
- **Shadow latch:** address 101 then `frame` → `road_left_q`=100. A mid-frame change to 200 without `frame` → `road_px` is unchanged (road still at 100..259).
- **Saturation:** address 0xFFF0 → right edge clips at 0xFFFF. `road_px`=1 at h=0xFFFF and 0 at h=0.
- **Dash scroll (`ROAD_DASH_EN`):** with `dash_run`=1, apply 3 frames → `dash_ofs`=6.
  - `v_pix`=10, h=178 → `stripe_px`=0.
  - `v_pix`=9 → `stripe_px`=1.
  - With `dash_run`=0, `dash_ofs` holds.
  - Build without the macro → stripe is solid for all `v_pix`.
- **Crash threshold:** 3 off-road car pixels then `frame` → `crash`=0. 4 off-road pixels then `frame` → `crash`=1, staying 1 across later frames. `crash_clr` → `crash`=0 the next cycle.
- **Reset mid-operation:** assert `reset`=0 mid-frame with `offcnt`=3 and `crash`=1 → all outputs go to 0 immediately. After release, a frame with 0 off-road pixels keeps `crash`=0.
